serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the single FTDI `serial_txd` line between `NUM_REQ` on-chip byte producers and drives it with an integrated 8N1 UART serializer. It runs off the `clk_48` domain from the HFOSC. Requesters present bytes on valid/ready handshakes, and arbitration is round-robin at packet granularity, so multi-byte messages never interleave. The block sits between the debug/status producers and the `serial_txd` pin.

## Interface
- `NUM_REQ`, 4: number of requesters, range 2..8.
- `DIVISOR`, 417: `clk_48` cycles per bit (48 MHz / 115200, rounded). Must be ≥ 2.
- `clk_48`  in  1  system clock, 48 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester i has a byte on its lane.
- `req_data`  in  8*NUM_REQ  byte lanes; lane i is bits [8i+7:8i].
- `req_last`  in  NUM_REQ  the byte on lane i ends its packet.
- `req_ready`  out  NUM_REQ  byte on lane i is accepted this cycle when valid is also high.
- `grant`  out  NUM_REQ  one-hot current owner; all zeros when idle and unlocked.
- `busy`  out  1  a frame is being shifted out.
- `serial_txd`  out  1  UART line; idles high.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only when `SERIAL_TX_PARITY_EN` is defined), STOP.
- **Arbitration (IDLE, unlocked):**
  - Combinational search begins at the round-robin pointer and moves upward, wrapping at `NUM_REQ`-1 → 0.
  - The first requester with `req_valid` is selected.
- **Arbitration (IDLE, locked):** only the owner is eligible, and other requesters are blocked.
  - If the owner drops `req_valid`, the block waits in IDLE with the lock held. No timeout.
- **Handshake:** `req_ready[i]` = (state==IDLE) && (selected==i), combinational. At most one bit is high at a time.
- **Transfer** happens on valid && ready. On a transfer the block:
  - latches the byte and its `req_last`;
  - sets `grant` to the owner;
  - goes to START.
- **Frame shape:**
  - START drives 0 for `DIVISOR` cycles.
  - DATA sends 8 bits LSB first, `DIVISOR` cycles each.
  - STOP drives 1 for `DIVISOR` cycles, then the block returns to IDLE.
- **End of STOP:**
  - If the latched `last`=0, the lock is held and `grant` is unchanged.
  - If `last`=1, the lock is released, `grant` goes to 0, and the pointer becomes owner+1 mod `NUM_REQ`.
- **Counters:**
  - Bit-period counter is `$clog2(DIVISOR)` bits wide; it reloads at 0 and counts to `DIVISOR`-1.
  - Bit index is 3 bits and wraps after bit 7 into the next state.
- `busy` is high in every state except IDLE.

## Timing
- **Reset values:**
  - `serial_txd`=1, `req_ready`=0, `grant`=0, `busy`=0.
  - Pointer=0, lock cleared, state IDLE.
- **Reset mid-operation:** takes effect in the cycle after `reset` is sampled high. The frame is truncated, the line returns high, and the lock and pointer are cleared.
- **Acceptance latency:** 0 cycles; a byte valid in IDLE is accepted in that same cycle.
- **TX latency:** `serial_txd` falls on the cycle after the transfer.
- **Frame length:** 10×`DIVISOR` cycles, or 11×`DIVISOR` with parity.
- **Back-to-back frames:** the STOP level is followed by exactly one IDLE cycle at 1 before the next START. The minimum frame pitch is 10×`DIVISOR`+1 cycles.
- **Registered outputs:** `grant`, `busy` and `serial_txd`.
- **Simultaneous events:** when several requesters assert valid together, the pointer decides. A requester that raises valid during a frame is considered at the next IDLE.

## Configuration
- **`SERIAL_TX_PARITY_EN` defined:** a PARITY state follows DATA. It drives even parity (XOR of the 8 data bits) for `DIVISOR` cycles, and the frame becomes 8E1.
- **Not defined:** the frame is 8N1, and the PARITY state and its logic are not built.

## Test plan
- **Single byte, DIVISOR=4:** req0 sends 0x55 with last=1.
  - `req_ready[0]` is high for 1 cycle.
  - `serial_txd` is 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles.
  - `busy` is high for 40 cycles; `grant` ends at 0.
- **Round robin:** req0 and req2 both valid with single-byte packets from reset. Order is req0, req2, req0, …
- **Packet lock:** req1 sends bytes 0x41, 0x42, 0x43, with last=1 only on 0x43, while req0 is held valid. No req0 byte appears on the line between 0x41 and 0x43. req0 is granted next, and the pointer moves to 2.
- **Lock stall:** req1 sends a first byte with last=0, then drops valid for 100 cycles while req3 is valid.
  - `grant` stays 0010 and `serial_txd` stays high.
  - req1 resumes with last=1, then req3 is served.
- **Wrap and reset:**
  - After the last grant goes to req3 (`NUM_REQ`=4), req0 and req3 are both valid. req0 wins.
  - Asserting `reset` during DATA bit 3 gives `serial_txd`=1, `busy`=0 and `grant`=0 on the next cycle.
- **Parity (`SERIAL_TX_PARITY_EN`):** byte 0x07 has parity bit 1 and byte 0x03 has parity bit 0. Frame length is 44 cycles at DIVISOR=4.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// serial_tx_arbiter
//   Round-robin, packet-locked arbiter feeding an 8N1 UART serializer.
//   Define SERIAL_TX_PARITY_EN for 8E1 frames (even parity bit after DATA).
//   Revision: 1.0
// ============================================================================
module serial_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DIVISOR = 417
) (
    input  logic                   clk_48_i,
    input  logic                   reset_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [8*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic                   busy_o,
    output logic                   serial_txd_o
);
    localparam int CNT_W = $clog2(DIVISOR);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DIVISOR - 1);
    localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(NUM_REQ - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SERIAL_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         data_q, data_d;
    logic               last_q, last_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic               lock_q, lock_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               txd_q, txd_d;

    logic               w_sel_valid;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTR_W-1:0]   w_cand;
    logic               w_bit_done;
    int                 w_idx;

    // Downward scan so the requester closest to the pointer is assigned last.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        w_idx       = 0;
        if (lock_q) begin
            w_sel_valid = req_valid_i[owner_q];
            w_sel_idx   = owner_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_idx = int'(ptr_q) + k;
                if (w_idx >= NUM_REQ) begin
                    w_idx = w_idx - NUM_REQ;
                end
                w_cand = PTR_W'(w_idx);
                if (req_valid_i[w_cand]) begin
                    w_sel_valid = 1'b1;
                    w_sel_idx   = w_cand;
                end
            end
        end
    end

    always_ff @(posedge clk_48_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            txd_q   <= txd_d;
        end
    end

    always_comb begin
        w_bit_done = (cnt_q == C_CNT_MAX);
        state_d    = state_q;
        cnt_d      = '0;
        bit_d      = bit_q;
        data_d     = data_q;
        last_d     = last_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        if (state_q != S_IDLE && !w_bit_done) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (w_sel_valid) begin
                    state_d = S_START;
                    data_d  = req_data_i[{w_sel_idx, 3'b000} +: 8];
                    last_d  = req_last_i[w_sel_idx];
                    owner_d = w_sel_idx;
                    lock_d  = 1'b1;
                    grant_d = NUM_REQ'(1) << w_sel_idx;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    state_d = S_IDLE;
                    if (last_q) begin
                        lock_d  = 1'b0;
                        grant_d = '0;
                        ptr_d   = (owner_q == C_PTR_MAX) ? '0 : owner_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line level is derived from next-state values so the registered pin lines up with the state.
    always_comb begin
        req_ready_o = '0;
        if (state_q == S_IDLE && w_sel_valid) begin
            req_ready_o[w_sel_idx] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        txd_d  = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = data_d[bit_d];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: txd_d = ^data_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    assign grant_o      = grant_q;
    assign busy_o       = busy_q;
    assign serial_txd_o = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_serial_tx_arbiter
//   Self-checking bench: lane drivers, UART frame monitor and byte scoreboard.
//   Revision: 1.0
// ============================================================================
module tb_serial_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DIVISOR = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * DIVISOR;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        txd;

    always #5 clk = ~clk;

    serial_tx_arbiter #(.NUM_REQ(NUM_REQ), .DIVISOR(DIVISOR)) u_dut (
        .clk_48_i     (clk),
        .reset_i      (rst),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_last_i   (req_last),
        .req_ready_o  (req_ready),
        .grant_o      (grant),
        .busy_o       (busy),
        .serial_txd_o (txd)
    );

    typedef struct packed { logic [7:0] d; logic l; } item_t;
    typedef struct { logic [3:0] g; logic [7:0] d; } exp_t;
    typedef struct { int lane; logic [7:0] d; logic [3:0] g; } vec_t;

    item_t lq [NUM_REQ][$];
    exp_t  sb [$];

    int nvec = 0, nfail = 0, cyc = 0, frames_done = 0;
    int fire_cyc = 0, start_cyc = 0, rdy0_cnt = 0, onehot_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send(input int lane, input logic [7:0] d, input logic l);
        lq[lane].push_back('{d, l});
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] d);
        sb.push_back('{g, d});
    endtask

    task automatic wait_frames(input int target, input string name);
        int budget = 0;
        while (frames_done < target && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check(name, 32'(frames_done >= target), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    // Lane drivers: present queue heads, retire an item after a handshake.
    initial begin : driver
        logic [3:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = rst ? 4'b0 : (req_valid & req_ready);
            if (req_ready[0]) rdy0_cnt++;
            if ($countones(req_ready) > 1) onehot_bad++;
            if (fire != 4'b0) fire_cyc = cyc;
            @(posedge clk); #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (fire[i] && lq[i].size() > 0) void'(lq[i].pop_front());
                if (lq[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = lq[i][0].d;
                    req_last[i]       = lq[i][0].l;
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    // Frame monitor: one sample per bit period, every other cycle must hold the level.
    initial begin : monitor
        int          pos;
        logic        in_frame;
        logic [FB-1:0] bits;
        logic        stab_bad, busy_bad;
        logic [3:0]  g0;
        exp_t        e;
        in_frame = 1'b0; pos = 0; bits = '0; stab_bad = 1'b0; busy_bad = 1'b0; g0 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else if (!in_frame) begin
                if (txd === 1'b0) begin
                    in_frame  = 1'b1;
                    pos       = 0;
                    bits      = '0;
                    g0        = grant;
                    stab_bad  = 1'b0;
                    busy_bad  = (busy !== 1'b1);
                    start_cyc = cyc;
                end
            end else begin
                pos++;
                if (pos < FRAME) begin
                    if (pos % DIVISOR == 0) bits[pos / DIVISOR] = txd;
                    else if (txd !== bits[pos / DIVISOR]) stab_bad = 1'b1;
                    if (busy !== 1'b1) busy_bad = 1'b1;
                end else begin
                    in_frame = 1'b0;
                    check("busy_frame", {30'd0, busy_bad, busy}, 32'd0);
                    check("bit_stable", {31'd0, stab_bad}, 32'd0);
                    check("stop_bit", {31'd0, bits[FB-1]}, 32'd1);
`ifdef SERIAL_TX_PARITY_EN
                    check("parity_bit", {31'd0, bits[9]}, {31'd0, ^bits[8:1]});
`endif
                    if (sb.size() == 0) begin
                        nvec++;
                        nfail++;
                        $display("FAIL unexpected_frame: got byte 0x%0h grant 0x%0h, expected no frame", bits[8:1], g0);
                    end else begin
                        e = sb.pop_front();
                        check("tx_byte", {24'd0, bits[8:1]}, {24'd0, e.d});
                        check("tx_grant", {28'd0, g0}, {28'd0, e.g});
                    end
                    frames_done++;
                end
            end
        end
    end

    initial begin : main
        vec_t tbl [6];
        int   nf, k, stall_bad;
        tbl[0] = '{1, 8'hA3, 4'b0010};
        tbl[1] = '{2, 8'h00, 4'b0100};
        tbl[2] = '{3, 8'hFF, 4'b1000};
        tbl[3] = '{0, 8'h07, 4'b0001};
        tbl[4] = '{2, 8'h03, 4'b0100};
        tbl[5] = '{3, 8'h80, 4'b1000};
        nf = 0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_txd",   {31'd0, txd}, 32'd1);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Single byte 0x55 on lane 0
        rdy0_cnt = 0;
        push_exp(4'b0001, 8'h55);
        send(0, 8'h55, 1'b1);
        nf++;
        wait_frames(nf, "single_done");
        check("single_ready_cycles", 32'(rdy0_cnt), 32'd1);
        check("single_latency", 32'(start_cyc - fire_cyc), 32'd1);
        @(negedge clk);
        check("single_grant_end", {28'd0, grant}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            push_exp(tbl[i].g, tbl[i].d);
            send(tbl[i].lane, tbl[i].d, 1'b1);
            nf++;
            wait_frames(nf, "table_done");
        end

        // Round robin between lanes 0 and 2 from reset
        do_reset();
        push_exp(4'b0001, 8'h10); push_exp(4'b0100, 8'h20);
        push_exp(4'b0001, 8'h11); push_exp(4'b0100, 8'h21);
        send(0, 8'h10, 1'b1); send(0, 8'h11, 1'b1);
        send(2, 8'h20, 1'b1); send(2, 8'h21, 1'b1);
        nf += 4;
        wait_frames(nf, "rr_done");

        // Packet lock: lane 0 waits out the whole lane 1 packet
        push_exp(4'b0010, 8'h41); push_exp(4'b0010, 8'h42); push_exp(4'b0010, 8'h43);
        push_exp(4'b0001, 8'h30);
        send(1, 8'h41, 1'b0); send(1, 8'h42, 1'b0); send(1, 8'h43, 1'b1);
        k = 0;
        while (grant !== 4'b0010 && k < 200) begin @(negedge clk); k++; end
        check("lock_granted", {28'd0, grant}, 32'h2);
        send(0, 8'h30, 1'b1);
        nf += 4;
        wait_frames(nf, "lock_done");

        // Lock stall: owner goes quiet while lane 3 is waiting
        push_exp(4'b0010, 8'h51);
        send(1, 8'h51, 1'b0); send(3, 8'h73, 1'b1);
        nf++;
        wait_frames(nf, "stall_first");
        stall_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (grant !== 4'b0010 || txd !== 1'b1 || busy !== 1'b0) stall_bad++;
        end
        check("stall_hold", 32'(stall_bad), 32'd0);
        push_exp(4'b0010, 8'h52); push_exp(4'b1000, 8'h73);
        send(1, 8'h52, 1'b1);
        nf += 2;
        wait_frames(nf, "stall_done");

        // Pointer wrap: lane 3 was last owner, lane 0 goes first
        push_exp(4'b0001, 8'h91); push_exp(4'b1000, 8'h90);
        send(3, 8'h90, 1'b1); send(0, 8'h91, 1'b1);
        nf += 2;
        wait_frames(nf, "wrap_done");

        // Reset during DATA bit 3 with a lock and a non-zero pointer
        push_exp(4'b0100, 8'hB0);
        send(2, 8'hB0, 1'b1);
        nf++;
        wait_frames(nf, "prereset_done");
        send(1, 8'hC5, 1'b0);
        k = 0;
        while (txd !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check("reset_frame_start", {31'd0, txd}, 32'd0);
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_prebit3", {31'd0, txd}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_txd",   {31'd0, txd}, 32'd1);
        check("reset_mid_busy",  {31'd0, busy}, 32'd0);
        check("reset_mid_grant", {28'd0, grant}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        push_exp(4'b0001, 8'hD0); push_exp(4'b1000, 8'hD3);
        send(3, 8'hD3, 1'b1); send(0, 8'hD0, 1'b1);
        nf += 2;
        wait_frames(nf, "postreset_done");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("ready_onehot", 32'(onehot_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
